sprite_fetch: RTL and testbench

SPRITE_FETCH -- requirements
Module: sprite_fetch

---
 rtl/sprite_fetch_pkg.sv | 22 ++
 rtl/fetch_delay.sv | 25 ++
 rtl/sprite_fetch.sv | 146 ++++++++++++++
 tb/tb_sprite_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_pkg.sv
// Shared sprite parameters: ROM address width, sprite dimensions and sprite-select encodings.
package sprite_fetch_pkg;

    localparam int unsigned SPRITE_ADDR_WIDTH = 12;

    localparam int unsigned DINO_W   = 44;
    localparam int unsigned DINO_H   = 47;
    localparam int unsigned DUCK_W   = 59;
    localparam int unsigned DUCK_H   = 30;
    localparam int unsigned CACTUS_W = 25;
    localparam int unsigned CACTUS_H = 50;
    localparam int unsigned BIRD_W   = 46;
    localparam int unsigned BIRD_H   = 40;

    typedef enum logic [1:0] {
        SEL_DINO   = 2'b00,
        SEL_DUCK   = 2'b01,
        SEL_CACTUS = 2'b10,
        SEL_BIRD   = 2'b11
    } sprite_sel_e;

endpackage

// File: rtl/fetch_delay.sv
// Parameterised-depth shift register with async active-high reset; aligns flags with the sprite ROM.
module fetch_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_fetch.sv
// Per-pixel sprite hit test and ROM address generation for the dino and one obstacle.
// Optional debug outline output enabled by defining SPRITE_FETCH_BBOX_EN.
module sprite_fetch
    import sprite_fetch_pkg::*;
#(
    parameter int unsigned SPRITE_ADDR_WIDTH = sprite_fetch_pkg::SPRITE_ADDR_WIDTH,
    parameter int unsigned COORD_W           = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [COORD_W-1:0]           i_x,
    input  logic [COORD_W-1:0]           i_y,
    input  logic                         i_de,
    input  logic                         i_frame_start,
    input  logic [COORD_W-1:0]           i_dino_x,
    input  logic [COORD_W-1:0]           i_dino_y,
    input  logic                         i_duck,
    input  logic [COORD_W-1:0]           i_obs_x,
    input  logic [COORD_W-1:0]           i_obs_y,
    input  logic                         i_obs_en,
    input  logic                         i_obs_bird,
    output logic [1:0]                   o_sel,
    output logic [SPRITE_ADDR_WIDTH-1:0] o_addr,
    output logic                         o_hit,
    output logic                         o_de,
    output logic                         o_bbox
);

    localparam int unsigned CW1 = COORD_W + 1;
    localparam int unsigned AW  = SPRITE_ADDR_WIDTH;
`ifdef SPRITE_FETCH_BBOX_EN
    localparam int unsigned FLAG_W = 3;
`else
    localparam int unsigned FLAG_W = 2;
`endif

    logic [COORD_W-1:0] dino_x_q, dino_y_q, obs_x_q, obs_y_q;
    logic               duck_q, obs_en_q, obs_bird_q;

    logic [CW1-1:0]     dino_w, dino_h, obs_w, obs_h;
    logic               dino_hit, obs_hit;
    logic [1:0]         sel_nxt;
    logic [AW-1:0]      addr_nxt;
    logic [FLAG_W-1:0]  flags_d, flags_q;

    // Extended-width compare so boxes near the right/bottom edge never wrap.
    function automatic logic in_span(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] o,
                                     input logic [CW1-1:0] len);
        return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} < ({1'b0, o} + len));
    endfunction

    function automatic logic [AW-1:0] rel_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                               input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy,
                                               input logic [CW1-1:0] w);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = x - ox;
        dy = y - oy;
        return AW'(AW'(dy) * AW'(w) + AW'(dx));
    endfunction

    // Shadow inputs become visible only at frame start, so a frame never tears.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dino_x_q   <= '0;
            dino_y_q   <= '0;
            duck_q     <= 1'b0;
            obs_x_q    <= '0;
            obs_y_q    <= '0;
            obs_en_q   <= 1'b0;
            obs_bird_q <= 1'b0;
        end else if (i_frame_start) begin
            dino_x_q   <= i_dino_x;
            dino_y_q   <= i_dino_y;
            duck_q     <= i_duck;
            obs_x_q    <= i_obs_x;
            obs_y_q    <= i_obs_y;
            obs_en_q   <= i_obs_en;
            obs_bird_q <= i_obs_bird;
        end
    end

    always_comb begin
        dino_w   = duck_q     ? CW1'(DUCK_W) : CW1'(DINO_W);
        dino_h   = duck_q     ? CW1'(DUCK_H) : CW1'(DINO_H);
        obs_w    = obs_bird_q ? CW1'(BIRD_W) : CW1'(CACTUS_W);
        obs_h    = obs_bird_q ? CW1'(BIRD_H) : CW1'(CACTUS_H);
        dino_hit = i_de && in_span(i_x, dino_x_q, dino_w) && in_span(i_y, dino_y_q, dino_h);
        obs_hit  = i_de && obs_en_q && in_span(i_x, obs_x_q, obs_w) && in_span(i_y, obs_y_q, obs_h);
        sel_nxt  = o_sel;
        addr_nxt = o_addr;
        if (dino_hit) begin
            sel_nxt  = duck_q ? SEL_DUCK : SEL_DINO;
            addr_nxt = rel_addr(i_x, i_y, dino_x_q, dino_y_q, dino_w);
        end else if (obs_hit) begin
            sel_nxt  = obs_bird_q ? SEL_BIRD : SEL_CACTUS;
            addr_nxt = rel_addr(i_x, i_y, obs_x_q, obs_y_q, obs_w);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sel  <= SEL_DINO;
            o_addr <= '0;
        end else begin
            o_sel  <= sel_nxt;
            o_addr <= addr_nxt;
        end
    end

`ifdef SPRITE_FETCH_BBOX_EN
    logic bbox_c;

    function automatic logic on_edge(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] o,
                                     input logic [CW1-1:0] len);
        return (p == o) || ({1'b0, p} == ({1'b0, o} + len - CW1'(1)));
    endfunction

    // Outline of every hit box, deliberately without dino/obstacle priority.
    always_comb begin
        bbox_c = (dino_hit && (on_edge(i_x, dino_x_q, dino_w) || on_edge(i_y, dino_y_q, dino_h)))
              || (obs_hit  && (on_edge(i_x, obs_x_q, obs_w)   || on_edge(i_y, obs_y_q, obs_h)));
    end

    assign flags_d = {dino_hit || obs_hit, i_de, bbox_c};
    assign o_bbox  = flags_q[0];
    assign o_de    = flags_q[1];
    assign o_hit   = flags_q[2];
`else
    assign flags_d = {dino_hit || obs_hit, i_de};
    assign o_bbox  = 1'b0;
    assign o_de    = flags_q[0];
    assign o_hit   = flags_q[1];
`endif

    fetch_delay #(
        .WIDTH (FLAG_W),
        .DEPTH (3)
    ) u_fetch_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (flags_d),
        .o_q   (flags_q)
    );

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: a reference model queues expected sel/addr and flags per pixel.
module tb_sprite_fetch;

    localparam int AW = 12;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] px = '0, py = '0;
    logic          de = 1'b0, fs = 1'b0;
    logic [CW-1:0] s_dx = '0, s_dy = '0, s_ox = '0, s_oy = '0;
    logic          s_duck = 1'b0, s_oen = 1'b0, s_bird = 1'b0;
    logic [1:0]    o_sel;
    logic [AW-1:0] o_addr;
    logic          o_hit, o_de, o_bbox;

    sprite_fetch #(.SPRITE_ADDR_WIDTH(AW), .COORD_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_x(px), .i_y(py), .i_de(de), .i_frame_start(fs),
        .i_dino_x(s_dx), .i_dino_y(s_dy), .i_duck(s_duck),
        .i_obs_x(s_ox), .i_obs_y(s_oy), .i_obs_en(s_oen), .i_obs_bird(s_bird),
        .o_sel(o_sel), .o_addr(o_addr), .o_hit(o_hit), .o_de(o_de), .o_bbox(o_bbox)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int sel; int addr; string tag; } sa_t;
    typedef struct { int due; int hit; int de; int bbox; string tag; } fl_t;
    sa_t q_sa[$];
    fl_t q_fl[$];

    int cyc = 0;
    int n_total = 0, n_bad = 0;
    // reference model state: active copies and held sel/addr
    int a_dx = 0, a_dy = 0, a_ox = 0, a_oy = 0, a_duck = 0, a_oen = 0, a_bird = 0;
    int m_sel = 0, m_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q_sa.size() > 0 && q_sa[0].due == cyc) begin
            sa_t e;
            e = q_sa.pop_front();
            check({"sel", e.tag}, 32'(o_sel), 32'(e.sel));
            check({"addr", e.tag}, 32'(o_addr), 32'(e.addr));
        end
        while (q_fl.size() > 0 && q_fl[0].due == cyc) begin
            fl_t f;
            f = q_fl.pop_front();
            check({"hit", f.tag}, 32'(o_hit), 32'(f.hit));
            check({"de", f.tag}, 32'(o_de), 32'(f.de));
            check({"bbox", f.tag}, 32'(o_bbox), 32'(f.bbox));
        end
    end

    task automatic drive(input int x, input int y, input bit d, input bit f);
        int dw, dh, ow, oh, bb;
        bit dhit, ohit;
        string tag;
        @(posedge clk); #1;
        px = CW'(x); py = CW'(y); de = d; fs = f;
        dw = a_duck ? 59 : 44;  dh = a_duck ? 30 : 47;
        ow = a_bird ? 46 : 25;  oh = a_bird ? 40 : 50;
        dhit = d && x >= a_dx && x < a_dx + dw && y >= a_dy && y < a_dy + dh;
        ohit = d && a_oen != 0 && x >= a_ox && x < a_ox + ow && y >= a_oy && y < a_oy + oh;
        if (dhit) begin
            m_sel = a_duck ? 1 : 0;
            m_addr = ((y - a_dy) * dw + (x - a_dx)) % (1 << AW);
        end else if (ohit) begin
            m_sel = a_bird ? 3 : 2;
            m_addr = ((y - a_oy) * ow + (x - a_ox)) % (1 << AW);
        end
        bb = 0;
`ifdef SPRITE_FETCH_BBOX_EN
        if (dhit && (x == a_dx || x == a_dx + dw - 1 || y == a_dy || y == a_dy + dh - 1)) bb = 1;
        if (ohit && (x == a_ox || x == a_ox + ow - 1 || y == a_oy || y == a_oy + oh - 1)) bb = 1;
`endif
        tag = $sformatf("(%0d,%0d)", x, y);
        q_sa.push_back('{cyc + 1, m_sel, m_addr, tag});
        q_fl.push_back('{cyc + 3, int'(dhit || ohit), int'(d), bb, tag});
        if (f) begin
            a_dx = int'(s_dx); a_dy = int'(s_dy); a_duck = int'(s_duck);
            a_ox = int'(s_ox); a_oy = int'(s_oy); a_oen = int'(s_oen); a_bird = int'(s_bird);
        end
    endtask

    task automatic scan(input int x, input int y);
        drive(x, y, 1'b1, 1'b0);
    endtask

    task automatic frame();
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        check("rst_sel", 32'(o_sel), 0);
        check("rst_addr", 32'(o_addr), 0);
        check("rst_hit", 32'(o_hit), 0);
        check("rst_de", 32'(o_de), 0);
        check("rst_bbox", 32'(o_bbox), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // before any frame start only the dino at (0,0) is drawable
        scan(10, 10); scan(44, 0); scan(43, 46); scan(0, 47);

        s_dx = 10'd50; s_dy = 10'd100;
        frame();
        scan(50, 100); scan(93, 146); scan(94, 146); scan(49, 100); scan(50, 147);
        drive(0, 0, 1'b0, 1'b0);

        // shadow change without frame start must not take effect
        s_dx = 10'd200;
        scan(50, 100); scan(200, 100);
        frame();
        scan(200, 100); scan(50, 100);

        s_dx = 10'd50; s_duck = 1'b1;
        s_ox = 10'd60; s_oy = 10'd110; s_oen = 1'b1; s_bird = 1'b1;
        frame();
        scan(60, 110); scan(110, 110); scan(105, 130); scan(80, 149); scan(80, 150);

        s_dx = 10'd500; s_dy = 10'd300; s_oen = 1'b0;
        frame();
        scan(60, 110); scan(105, 130);

        s_ox = 10'd1000; s_oy = 10'd0; s_oen = 1'b1; s_bird = 1'b0;
        frame();
        scan(1023, 0); scan(0, 0); scan(1023, 49); scan(1023, 50); scan(1000, 25); scan(999, 25);

        s_dx = 10'd50; s_dy = 10'd100; s_duck = 1'b0;
        frame();
        scan(50, 120); scan(60, 120); scan(93, 120); scan(60, 146);

        s_dx = 10'd300; s_dy = 10'd200; s_ox = 10'd320; s_oy = 10'd220; s_bird = 1'b1;
        frame();
        for (int i = 0; i < 60; i++) scan(int'($urandom_range(290, 380)), int'($urandom_range(190, 270)));

        // asynchronous reset in the middle of a line
        scan(310, 210); scan(311, 210); scan(312, 210); scan(313, 210);
        @(posedge clk); #1;
        rst = 1'b1; de = 1'b0;
        #1;
        check("arst_sel", 32'(o_sel), 0);
        check("arst_addr", 32'(o_addr), 0);
        check("arst_hit", 32'(o_hit), 0);
        check("arst_de", 32'(o_de), 0);
        check("arst_bbox", 32'(o_bbox), 0);
        q_sa.delete(); q_fl.delete();
        a_dx = 0; a_dy = 0; a_duck = 0; a_ox = 0; a_oy = 0; a_oen = 0; a_bird = 0;
        m_sel = 0; m_addr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        scan(5, 5); scan(310, 210); scan(43, 46); scan(44, 46);

        repeat (4) drive(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && (q_sa.size() > 0 || q_fl.size() > 0); i++) @(negedge clk);
        #1;
        if (q_sa.size() > 0 || q_fl.size() > 0) check("drain", 32'(q_sa.size() + q_fl.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
